// File: rtl/sram_port_arbiter_if.sv
// Requester handshake and shared SRAM port of sram_port_arbiter, bundled with
// slave (arbiter) and master (requesters + SRAM model) views.
interface sram_port_arbiter_if #(
    parameter int NumPorts = 2,
    parameter int Width    = 32,
    parameter int Depth    = 1 << 15
);
    localparam int WidthBytes = Width / 8;
    localparam int Aw         = $clog2(Depth);

    logic [NumPorts-1:0]                 req_i;
    logic [NumPorts-1:0]                 gnt_o;
    logic [NumPorts-1:0]                 we_i;
    logic [NumPorts-1:0][63:0]           addr_i;
    logic [NumPorts-1:0][Width-1:0]      wdata_i;
    logic [NumPorts-1:0][WidthBytes-1:0] be_i;
    logic [NumPorts-1:0]                 rvalid_o;
    logic [NumPorts-1:0][Width-1:0]      rdata_o;
    logic [NumPorts-1:0]                 err_o;

    logic                  sram_req_o;
    logic                  sram_write_o;
    logic [Aw-1:0]         sram_addr_o;
    logic [Width-1:0]      sram_wdata_o;
    logic [WidthBytes-1:0] sram_wmask_o;
    logic [Width-1:0]      sram_rdata_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i, sram_rdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
               sram_req_o, sram_write_o, sram_addr_o, sram_wdata_o, sram_wmask_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i, sram_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
               sram_req_o, sram_write_o, sram_addr_o, sram_wdata_o, sram_wmask_o
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NumPorts requesters.
// Define SRAM_PORT_ARBITER_RANGE_CHECK_EN to flag out-of-window addresses with err_o.
module sram_port_arbiter #(
    parameter int          NumPorts = 2,
    parameter int          Width    = 32,
    parameter int          Depth    = 1 << 15,
    parameter logic [63:0] AddrBase = 64'h8000_0000
) (
    input logic               clk_i,
    input logic               rst_i,
    sram_port_arbiter_if.slave bus
);
    localparam int WidthBytes = Width / 8;
    localparam int Aw         = $clog2(Depth);
    localparam int Off        = $clog2(WidthBytes);
    localparam int PtrW       = $clog2(NumPorts);

    logic [PtrW-1:0]       last_q;
    logic [PtrW-1:0]       sel;
    logic                  accept;
    logic                  sel_we;
    logic [63:0]           sel_addr;
    logic [Width-1:0]      sel_wdata;
    logic [WidthBytes-1:0] sel_be;
    logic [63:0]           offset;
    logic [Aw-1:0]         idx;
    logic                  in_range;

    logic                  resp_valid_q;
    logic [PtrW-1:0]       resp_port_q;
    logic                  resp_we_q;
    logic                  resp_err_q;

    function automatic logic [PtrW-1:0] rr_index(input logic [PtrW-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        return PtrW'(sum % NumPorts);
    endfunction

    // Walk from lowest to highest priority so the last match (last+1 first) wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        sel    = '0;
        accept = 1'b0;
        for (int k = NumPorts; k >= 1; k--) begin
            if (bus.req_i[rr_index(last_q, k)]) begin
                sel    = rr_index(last_q, k);
                accept = !rst_i;
            end
        end
    end

    always_comb begin
        bus.gnt_o = '0;
        if (accept) bus.gnt_o[sel] = 1'b1;
    end

    assign sel_we    = bus.we_i[sel];
    assign sel_addr  = bus.addr_i[sel];
    assign sel_wdata = bus.wdata_i[sel];
    assign sel_be    = bus.be_i[sel];
    assign offset    = sel_addr - AddrBase;
    assign idx       = Aw'(offset >> Off);

`ifdef SRAM_PORT_ARBITER_RANGE_CHECK_EN
    localparam logic [63:0] Span = 64'(Depth) * 64'(WidthBytes);
    assign in_range = (sel_addr >= AddrBase) && (offset < Span);
`else
    assign in_range = 1'b1;
`endif

    always_comb begin
        bus.sram_req_o   = accept && in_range;
        bus.sram_write_o = accept && in_range && sel_we;
        bus.sram_addr_o  = bus.sram_req_o ? idx : '0;
        bus.sram_wdata_o = bus.sram_req_o ? sel_wdata : '0;
        bus.sram_wmask_o = bus.sram_req_o ? sel_be : '0;
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            last_q       <= PtrW'(NumPorts - 1);
            resp_valid_q <= 1'b0;
            resp_port_q  <= '0;
            resp_we_q    <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= accept;
            if (accept) begin
                last_q      <= sel;
                resp_port_q <= sel;
                resp_we_q   <= sel_we;
                resp_err_q  <= !in_range;
            end
        end
    end

    // Rejected (out-of-window) accesses never reached the SRAM, so their data is forced to 0.
    always_comb begin
        bus.rvalid_o = '0;
        bus.rdata_o  = '0;
        bus.err_o    = '0;
        if (resp_valid_q && !rst_i) begin
            bus.rvalid_o[resp_port_q] = 1'b1;
            bus.rdata_o[resp_port_q]  = (resp_we_q || resp_err_q) ? '0 : bus.sram_rdata_i;
            bus.err_o[resp_port_q]    = resp_err_q;
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized self-checking bench for sram_port_arbiter against a transaction-level model.
module tb_sram_port_arbiter;
    localparam int          NumPorts   = 3;
    localparam int          Width      = 32;
    localparam int          Depth      = 1 << 15;
    localparam int          WidthBytes = Width / 8;
    localparam logic [63:0] AddrBase   = 64'h8000_0000;

    typedef struct {
        bit                    active;
        bit                    we;
        logic [63:0]           addr;
        logic [Width-1:0]      wdata;
        logic [WidthBytes-1:0] be;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_cmd = 1'b1;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.NumPorts(NumPorts), .Width(Width), .Depth(Depth)) bus ();

    sram_port_arbiter #(
        .NumPorts(NumPorts), .Width(Width), .Depth(Depth), .AddrBase(AddrBase)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    // Environment SRAM: one access per cycle, read data one cycle later.
    logic [Width-1:0] sram_mem [Depth];
    logic [Width-1:0] sram_rdata = '0;
    assign bus.sram_rdata_i = sram_rdata;

    always @(posedge clk) begin
        if (bus.sram_req_o) begin
            if (bus.sram_write_o) begin
                for (int b = 0; b < WidthBytes; b++)
                    if (bus.sram_wmask_o[b]) sram_mem[bus.sram_addr_o][8*b +: 8] <= bus.sram_wdata_o[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[bus.sram_addr_o];
            end
        end
    end

    // Transaction-level reference state.
    logic [Width-1:0] ref_mem [Depth];
    req_t             pend [NumPorts];
    int               last_m = NumPorts - 1;
    bit               resp_pend = 1'b0;
    int               resp_port = 0;
    logic [Width-1:0] resp_data = '0;
    bit               resp_err = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_window(input logic [63:0] a);
`ifdef SRAM_PORT_ARBITER_RANGE_CHECK_EN
        return (a >= AddrBase) && (a < AddrBase + 64'(Depth) * 64'(WidthBytes));
`else
        return (a == a);
`endif
    endfunction

    function automatic int word_of(input logic [63:0] a);
        logic [63:0] w;
        w = ((a - AddrBase) / 64'(WidthBytes)) % 64'(Depth);
        return int'(w);
    endfunction

    task automatic post(input int p, input bit we, input logic [63:0] addr,
                        input logic [Width-1:0] wdata, input logic [WidthBytes-1:0] be);
        if (!pend[p].active) begin
            pend[p].active = 1'b1;
            pend[p].we     = we;
            pend[p].addr   = addr;
            pend[p].wdata  = wdata;
            pend[p].be     = be;
        end
    endtask

    // One cycle: drive at negedge, compare every output against the model, advance the model.
    task automatic step();
        int          win;
        bit          exp_req;
        bit          exp_rv;
        logic [63:0] exp_gnt;
        int          w;
        @(negedge clk);
        rst = rst_cmd;
        for (int p = 0; p < NumPorts; p++) begin
            bus.req_i[p]   = pend[p].active;
            bus.we_i[p]    = pend[p].we;
            bus.addr_i[p]  = pend[p].addr;
            bus.wdata_i[p] = pend[p].wdata;
            bus.be_i[p]    = pend[p].be;
        end
        #1;
        win = -1;
        if (!rst)
            for (int k = 1; k <= NumPorts && win < 0; k++)
                if (pend[(last_m + k) % NumPorts].active) win = (last_m + k) % NumPorts;
        exp_gnt = '0;
        if (win >= 0) exp_gnt[win] = 1'b1;
        exp_req = (win >= 0) && in_window(pend[win].addr);
        check("gnt", 64'(bus.gnt_o), exp_gnt);
        check("sram_req", 64'(bus.sram_req_o), 64'(exp_req));
        check("sram_write", 64'(bus.sram_write_o), 64'(exp_req && pend[win].we));
        if (exp_req) begin
            check("sram_addr", 64'(bus.sram_addr_o), 64'(word_of(pend[win].addr)));
            if (pend[win].we) begin
                check("sram_wdata", 64'(bus.sram_wdata_o), 64'(pend[win].wdata));
                check("sram_wmask", 64'(bus.sram_wmask_o), 64'(pend[win].be));
            end
        end
        for (int p = 0; p < NumPorts; p++) begin
            exp_rv = !rst && resp_pend && (resp_port == p);
            check($sformatf("rvalid[%0d]", p), 64'(bus.rvalid_o[p]), 64'(exp_rv));
            check($sformatf("rdata[%0d]", p), 64'(bus.rdata_o[p]), exp_rv ? 64'(resp_data) : 64'(0));
            check($sformatf("err[%0d]", p), 64'(bus.err_o[p]), 64'(exp_rv && resp_err));
        end
        resp_pend = 1'b0;
        if (rst) begin
            last_m = NumPorts - 1;
        end else if (win >= 0) begin
            resp_pend = 1'b1;
            resp_port = win;
            resp_err  = !in_window(pend[win].addr);
            resp_data = '0;
            if (!resp_err) begin
                w = word_of(pend[win].addr);
                if (pend[win].we) begin
                    for (int b = 0; b < WidthBytes; b++)
                        if (pend[win].be[b]) ref_mem[w][8*b +: 8] = pend[win].wdata[8*b +: 8];
                end else begin
                    resp_data = ref_mem[w];
                end
            end
            last_m = win;
            pend[win].active = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < NumPorts + 1; i++) step();
    endtask

    function automatic logic [63:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 99);
        if (sel < 75) return AddrBase + 64'(WidthBytes * $urandom_range(0, 31)) + 64'($urandom_range(0, 3));
        if (sel < 88) return AddrBase + 64'(WidthBytes) * 64'($urandom_range(0, Depth - 1));
        if (sel < 94) return AddrBase - 64'(WidthBytes * $urandom_range(1, 8));
        return AddrBase + 64'(Depth) * 64'(WidthBytes) + 64'(WidthBytes * $urandom_range(0, 8));
    endfunction

    initial begin
        for (int i = 0; i < Depth; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        sram_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4]  = 32'hDEAD_BEEF;
        for (int p = 0; p < NumPorts; p++) pend[p] = '{1'b0, 1'b0, 64'd0, '0, '0};
        bus.req_i = '0; bus.we_i = '0; bus.addr_i = '0; bus.wdata_i = '0; bus.be_i = '0;

        // Reset state.
        rst_cmd = 1'b1;
        step();
        check("reset_gnt", 64'(bus.gnt_o), 64'd0);
        check("reset_rvalid", 64'(bus.rvalid_o), 64'd0);
        step();
        rst_cmd = 1'b0;

        // Single read of word 4.
        post(0, 1'b0, AddrBase + 64'h10, '0, '0);
        step();
        check("rd_addr", 64'(bus.sram_addr_o), 64'd4);
        step();
        check("rd_rvalid", 64'(bus.rvalid_o[0]), 64'd1);
        check("rd_data", 64'(bus.rdata_o[0]), 64'hDEAD_BEEF);

        // Partial write then read-back on port 1.
        post(1, 1'b1, AddrBase + 64'h8, 32'h1234_5678, 4'b0011);
        step();
        post(1, 1'b0, AddrBase + 64'h8, '0, '0);
        step();
        check("wr_ack_rvalid", 64'(bus.rvalid_o[1]), 64'd1);
        check("wr_ack_data", 64'(bus.rdata_o[1]), 64'd0);
        step();
        check("rb_data", 64'(bus.rdata_o[1]), 64'h0000_5678);

        // Contention right after reset: 0,1,0,1.
        rst_cmd = 1'b1;
        step();
        rst_cmd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            post(0, 1'b0, AddrBase + 64'(4 * i), '0, '0);
            post(1, 1'b0, AddrBase + 64'(4 * i + 16), '0, '0);
            step();
            check("cont_gnt", 64'(bus.gnt_o), (i % 2 == 0) ? 64'd1 : 64'd2);
        end
        drain();

        // Reset the cycle after an accepted read.
        post(0, 1'b0, AddrBase + 64'h10, '0, '0);
        step();
        post(1, 1'b0, AddrBase, '0, '0);
        step();
        rst_cmd = 1'b1;
        step();
        check("rst_mid_rvalid", 64'(bus.rvalid_o), 64'd0);
        rst_cmd = 1'b0;
        pend[1].active = 1'b0;
        step();
        check("rst_after_rvalid", 64'(bus.rvalid_o), 64'd0);
        post(0, 1'b0, AddrBase, '0, '0);
        post(1, 1'b0, AddrBase, '0, '0);
        step();
        check("rst_prio_gnt", 64'(bus.gnt_o), 64'd1);
        drain();

        // Address just below the window.
        post(0, 1'b0, AddrBase - 64'd4, '0, '0);
        step();
`ifdef SRAM_PORT_ARBITER_RANGE_CHECK_EN
        check("range_sram_req", 64'(bus.sram_req_o), 64'd0);
        step();
        check("range_rvalid", 64'(bus.rvalid_o[0]), 64'd1);
        check("range_err", 64'(bus.err_o[0]), 64'd1);
`else
        check("wrap_sram_addr", 64'(bus.sram_addr_o), 64'(Depth - 1));
        step();
        check("wrap_rvalid", 64'(bus.rvalid_o[0]), 64'd1);
        check("wrap_err", 64'(bus.err_o[0]), 64'd0);
`endif

        // Back-to-back reads on port 0.
        for (int i = 0; i < 8; i++) begin
            post(0, 1'b0, AddrBase + 64'(4 * i), '0, '0);
            step();
            check("b2b_gnt", 64'(bus.gnt_o), 64'd1);
            if (i > 0) check("b2b_rvalid", 64'(bus.rvalid_o[0]), 64'd1);
        end
        step();
        check("b2b_last_rvalid", 64'(bus.rvalid_o[0]), 64'd1);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < NumPorts; p++)
                if ($urandom_range(0, 99) < 55)
                    post(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom(), WidthBytes'($urandom_range(0, 15)));
            rst_cmd = ($urandom_range(0, 199) == 0);
            step();
        end
        rst_cmd = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
